// File: rtl/eb_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : eb_skid_if
// Description : valid/ready stream bundle for eb_skid. The t_* signals are the
//               upstream side of the block, the i_* signals its downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
interface eb_skid_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] t_data;
  logic              t_valid;
  logic              t_ready;
  logic [DWIDTH-1:0] i_data;
  logic              i_valid;
  logic              i_ready;

  // Seen from the elastic stage: it consumes t_* and produces i_*.
  modport slave (
    input  t_data, t_valid, i_ready,
    output t_ready, i_data, i_valid
  );

  // Seen from the surrounding logic: it drives t_* and consumes i_*.
  modport master (
    output t_data, t_valid, i_ready,
    input  t_ready, i_data, i_valid
  );
endinterface
`default_nettype wire

// File: rtl/eb_skid.sv
`default_nettype none
// ============================================================================
// Module      : eb_skid
// Description : Two-entry elastic stage. Data/valid and ready are all
//               registered, so no combinational path crosses the block.
//               A skid register absorbs the one-cycle ready latency,
//               which keeps throughput at one beat per cycle.
//               Optional statistics counters are built when the macro
//               EB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module eb_skid #(
  parameter int DWIDTH = 32
`ifdef EB_STATS_EN
  , parameter int CWIDTH = 16
`endif
) (
  input  logic      clk,
  input  logic      rstf,
  eb_skid_if.slave  bus
`ifdef EB_STATS_EN
  , input  logic              stat_clr
  , output logic [CWIDTH-1:0] stat_xfer
  , output logic [CWIDTH-1:0] stat_stall
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] main_q, main_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              t_ready_q, t_ready_d;
  logic              i_valid_q, i_valid_d;
  logic              xfer_in, xfer_out;

  // Handshakes use the registered ready/valid, so inputs are ignored when
  // the block is not offering the matching half of the handshake.
  assign xfer_in  = bus.t_valid & t_ready_q;
  assign xfer_out = i_valid_q & bus.i_ready;

  // Next-state, storage update and registered output decode.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (xfer_in) begin
          state_d = S_ONE;
          main_d  = bus.t_data;
        end
      end
      S_ONE: begin
        if (xfer_in && xfer_out) begin
          main_d = bus.t_data;
        end else if (xfer_in) begin
          state_d = S_FULL;
          skid_d  = bus.t_data;
        end else if (xfer_out) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // t_ready is low here, so only the drain side can move.
        if (xfer_out) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Outputs are flops fed from the next state, so they match the state
    // register on every cycle without any combinational decode afterwards.
    t_ready_d = (state_d != S_FULL);
    i_valid_d = (state_d != S_EMPTY);
  end

  // State and datapath registers; reset drops any held beats.
  always_ff @(posedge clk) begin
    if (!rstf) begin
      state_q   <= S_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      t_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      t_ready_q <= t_ready_d;
      i_valid_q <= i_valid_d;
    end
  end

  assign bus.t_ready = t_ready_q;
  assign bus.i_valid = i_valid_q;
  assign bus.i_data  = main_q;

`ifdef EB_STATS_EN
  logic [CWIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CWIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic              stall_ev;

  assign stall_ev = i_valid_q & ~bus.i_ready;

  // Saturating event counters; a clear in the same cycle as an event wins.
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      xfer_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (xfer_out && (xfer_cnt_q != {CWIDTH{1'b1}}))
        xfer_cnt_d = xfer_cnt_q + 1'b1;
      if (stall_ev && (stall_cnt_q != {CWIDTH{1'b1}}))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rstf) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_xfer  = xfer_cnt_q;
  assign stat_stall = stall_cnt_q;
`endif

endmodule
`default_nettype wire
